// File: rtl/fdu_failover_pkg.sv
// Shared types for the FDU failover controller: FSM states, fault-count width, priority helper.
package fdu_failover_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // Wide enough for MAX_FAULTS up to 15.
    localparam int FCNT_W = 4;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/fdu_health_filter.sv
// Per-channel health debounce: trusted only after HOLDOFF consecutive high samples, dropped at once.
module fdu_health_filter #(
    parameter int HOLDOFF = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic health_i,
    output logic deb_o
);

    localparam int CW = $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] HOLD_V = CW'(HOLDOFF);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!health_i) begin
            cnt_d = '0;
        end else if (cnt_q != HOLD_V) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign deb_o = (cnt_q == HOLD_V);

endmodule

// File: rtl/fdu_failover_ctrl.sv
// Failover controller: filters channel health, selects lowest-index eligible channel, locks out repeat offenders.
// Optional build macro FDU_FAILOVER_REVERT_EN: revert to a recovered higher-priority channel.
//
// state     | meaning
// ST_INIT   | controller disabled, outputs idle
// ST_SCAN   | looking for an eligible channel (all_failed when none)
// ST_ACTIVE | a channel is selected and driving the mux
module fdu_failover_ctrl #(
    parameter int NUM_CH     = 3,
    parameter int HOLDOFF    = 16,
    parameter int MAX_FAULTS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] health,
    input  logic              enable,
    input  logic              clear_lockout,
    output logic [1:0]        active_ch,
    output logic              active_valid,
    output logic              switch_pulse,
    output logic [NUM_CH-1:0] locked_out,
    output logic              all_failed
);
    import fdu_failover_pkg::*;

    localparam logic [FCNT_W-1:0] MAX_V = FCNT_W'(MAX_FAULTS);

    state_e            state_q, state_d;
    logic [1:0]        ch_q, ch_d;
    logic              switch_q, switch_d;
    logic [FCNT_W-1:0] fcnt_q [NUM_CH];
    logic [FCNT_W-1:0] fcnt_d [NUM_CH];

    logic [NUM_CH-1:0] deb, eligible;
    logic [3:0]        deb_pad, elig_pad;
    logic [1:0]        best;
    logic              any_elig, fault, revert;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fdu_health_filter #(.HOLDOFF(HOLDOFF)) u_filt (
            .clk      (clk),
            .reset    (reset),
            .health_i (health[g]),
            .deb_o    (deb[g])
        );
        assign locked_out[g] = (fcnt_q[g] == MAX_V);
    end

    assign eligible = deb & ~locked_out;
    assign deb_pad  = 4'(deb);
    assign elig_pad = 4'(eligible);
    assign any_elig = |eligible;
    assign best     = lowest_set(elig_pad);
    assign fault    = (state_q == ST_ACTIVE) && !deb_pad[ch_q];

`ifdef FDU_FAILOVER_REVERT_EN
    assign revert = any_elig && (best < ch_q);
`else
    assign revert = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            ch_q     <= 2'd0;
            switch_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            switch_q <= switch_d;
            for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        switch_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (enable) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_INIT;
                end else if (any_elig) begin
                    state_d  = ST_ACTIVE;
                    ch_d     = best;
                    switch_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!enable)              state_d = ST_INIT;
                else if (fault || revert) state_d = ST_SCAN;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Clear applies before the fault increment, so a coincident fault leaves a count of one.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic [FCNT_W-1:0] base;
            base = clear_lockout ? '0 : fcnt_q[i];
            if (fault && (ch_q == 2'(i)) && (base != MAX_V)) base = base + 1'b1;
            fcnt_d[i] = base;
        end
    end

    always_comb begin
        active_valid = (state_q == ST_ACTIVE);
        active_ch    = active_valid ? ch_q : 2'd0;
        switch_pulse = switch_q;
        all_failed   = (state_q == ST_SCAN) && !any_elig;
    end

endmodule
